ddr_burst_arbiter: RTL and testbench
====================================

DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- BURST_LEN, 5, words per DDR burst; drives wr_burst_len and rd_burst_len.
- REGION_BASE, 0, first DDR word address of the circular buffer.
- REGION_SIZE, 40, buffer size in words; SHALL be a nonzero multiple of BURST_LEN.
- LVL_W, 16, width of the fill counter.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- phy_clk, in, 1, sole clock (controller PHY clock).
- rst_n, in, 1, asynchronous active-low reset.
- local_init_done, in, 1, DDR calibration complete.
- wr_src_ready, in, 1, AD-side FIFO holds at least BURST_LEN words.
- rd_sink_ready, in, 1, filter side can accept BURST_LEN words.
- wr_burst_req, out, 1, write burst request to ddr_ctrl.
- wr_burst_len, out, 10, constant BURST_LEN.
- wr_burst_addr, out, 25, write burst address.
- wr_burst_data_req, in, 1, ddr_ctrl write-accept indication.
- wr_burst_finish, in, 1, write burst complete (1-cycle pulse).
- rd_burst_req, out, 1, read burst request.
- rd_burst_len, out, 10, constant BURST_LEN.
- rd_burst_addr, out, 25, read burst address.
- rd_burst_data_valid, in, 1, first read data returned.
- rd_burst_finish, in, 1, read burst complete (1-cycle pulse).
- wr_done, out, 1, 1-cycle pulse when a write burst retires.
- rd_done, out, 1, 1-cycle pulse when a read burst retires.
- fill_level, out, LVL_W, words written but not yet read.
- buf_full, out, 1, fill_level greater than REGION_SIZE-BURST_LEN.
- buf_empty, out, 1, fill_level less than BURST_LEN.
- state_out, out, 3, current FSM state code.

Function
REQ-003 The FSM SHALL have states IDLE=0, WR_REQ=1, WR_BUSY=2, RD_REQ=3, RD_BUSY=4; codes 5–7 SHALL return to IDLE on the next cycle.
REQ-004 In IDLE with local_init_done=0, the FSM SHALL remain in IDLE with both request outputs low.
REQ-005 Write eligibility SHALL be wr_src_ready=1 and buf_full=0; read eligibility SHALL be rd_sink_ready=1 and buf_empty=0.
REQ-006 If only one side is eligible in IDLE, that side SHALL be granted on the next clock (IDLE→WR_REQ or IDLE→RD_REQ).
REQ-007 If both sides are eligible in IDLE, the side not granted last SHALL win (round-robin); last_grant SHALL reset to "read", so write wins first.
REQ-008 In WR_REQ, wr_burst_req SHALL be 1 and wr_burst_addr SHALL be REGION_BASE+wr_ptr.
REQ-009 wr_burst_req SHALL stay high until wr_burst_data_req=1; the next state SHALL then be WR_BUSY with wr_burst_req=0.
REQ-010 In WR_BUSY, wr_burst_finish=1 SHALL:
- advance wr_ptr by BURST_LEN;
- increase fill_level by BURST_LEN;
- pulse wr_done;
- return the FSM to IDLE.
REQ-011 RD_REQ and RD_BUSY SHALL mirror REQ-008..010, using rd_burst_data_valid as the accept, rd_ptr as the address, and decreasing fill_level by BURST_LEN.
REQ-012 A finish pulse arriving in a REQ state (same cycle as the accept, or before it) SHALL retire the burst directly to IDLE, with the same pointer, level and pulse updates.
REQ-013 A finish pulse in a state not owning that direction SHALL be ignored.
REQ-014 Pointer wrap: if ptr+BURST_LEN equals REGION_SIZE, the pointer SHALL become 0; pointers SHALL never equal or exceed REGION_SIZE.
REQ-015 Only one burst SHALL be outstanding at a time; wr_burst_req and rd_burst_req SHALL never both be 1.
REQ-016 fill_level SHALL never exceed REGION_SIZE nor go below 0; eligibility (REQ-005) guarantees this.
REQ-017 buf_full and buf_empty SHALL be combinational from fill_level.
REQ-018 wr_burst_addr and rd_burst_addr SHALL be registered and SHALL hold their value outside REQ states.
REQ-019 Deassertion of local_init_done mid-burst SHALL NOT abort the burst; only IDLE exits are gated by it.

Reset
REQ-020 On rst_n=0, asynchronously:
- state SHALL be IDLE;
- wr_ptr, rd_ptr and fill_level SHALL be 0;
- wr_burst_req, rd_burst_req, wr_done and rd_done SHALL be 0;
- both addresses SHALL be REGION_BASE;
- last_grant SHALL be "read".
REQ-021 Reset mid-burst SHALL discard the burst with no pointer update; buf_empty SHALL read 1 in the first cycle after release.

Verification
REQ-022 Bench scenarios (stimulus -> required response):
- Init gate: local_init_done=0, wr_src_ready=1 for 100 cycles -> no wr_burst_req; then init=1 -> WR_REQ next cycle, addr 0.
- Single write: accept at cycle 3, finish at cycle 9 -> wr_done pulse; fill_level=5; next write addr=5.
- Round robin: fill=10, wr_src_ready=rd_sink_ready=1 continuously -> grants W,R,W,R...; rd_burst_addr sequence 0,5,10.
- Full/wrap: 8 writes with no reads -> fill=40, buf_full=1, no further wr_burst_req; after 1 read, write resumes at addr 0.
- Early finish: finish asserted in the same cycle as wr_burst_data_req in WR_REQ -> IDLE next cycle, single wr_done, fill +5.
- Reset in WR_BUSY -> all outputs at reset values immediately; fill_level=0.

Source files
------------

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter for a circular DDR buffer. It issues one write or one read
// burst at a time and tracks the buffer pointers and the fill level.
//
// state   | meaning
// IDLE    | no burst outstanding; grants a side when local_init_done=1
// WR_REQ  | wr_burst_req high, waiting for ddr_ctrl to accept
// WR_BUSY | write accepted, waiting for wr_burst_finish
// RD_REQ  | rd_burst_req high, waiting for first read data
// RD_BUSY | read accepted, waiting for rd_burst_finish
module ddr_burst_arbiter #(
  parameter int BURST_LEN   = 5,
  parameter int REGION_BASE = 0,
  parameter int REGION_SIZE = 40,
  parameter int LVL_W       = 16
) (
  input  logic             phy_clk,
  input  logic             rst_n,
  input  logic             local_init_done,
  input  logic             wr_src_ready,
  input  logic             rd_sink_ready,
  output logic             wr_burst_req,
  output logic [9:0]       wr_burst_len,
  output logic [24:0]      wr_burst_addr,
  input  logic             wr_burst_data_req,
  input  logic             wr_burst_finish,
  output logic             rd_burst_req,
  output logic [9:0]       rd_burst_len,
  output logic [24:0]      rd_burst_addr,
  input  logic             rd_burst_data_valid,
  input  logic             rd_burst_finish,
  output logic             wr_done,
  output logic             rd_done,
  output logic [LVL_W-1:0] fill_level,
  output logic             buf_full,
  output logic             buf_empty,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_BUSY = 3'd2,
    RD_REQ  = 3'd3,
    RD_BUSY = 3'd4
  } state_t;

  localparam logic [24:0]      BASE_A  = 25'(REGION_BASE);
  localparam logic [24:0]      BL_A    = 25'(BURST_LEN);
  localparam logic [24:0]      SIZE_A  = 25'(REGION_SIZE);
  localparam logic [LVL_W-1:0] BL_L    = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] FULL_TH = LVL_W'(REGION_SIZE - BURST_LEN);

  state_t      state;
  logic        last_rd;
  logic [24:0] wr_ptr;
  logic [24:0] rd_ptr;
  logic [24:0] wr_ptr_nxt;
  logic [24:0] rd_ptr_nxt;
  logic        wr_elig;
  logic        rd_elig;
  logic        grant_wr;
  logic        grant_rd;

  assign wr_burst_len = 10'(BURST_LEN);
  assign rd_burst_len = 10'(BURST_LEN);
  assign state_out    = state;

  assign buf_full  = fill_level > FULL_TH;
  assign buf_empty = fill_level < BL_L;

  assign wr_elig = wr_src_ready & ~buf_full;
  assign rd_elig = rd_sink_ready & ~buf_empty;

  // On contention the side that did not win last time gets the grant.
  assign grant_wr = local_init_done & wr_elig & (~rd_elig | last_rd);
  assign grant_rd = local_init_done & rd_elig & (~wr_elig | ~last_rd);

  assign wr_ptr_nxt = (wr_ptr + BL_A == SIZE_A) ? '0 : wr_ptr + BL_A;
  assign rd_ptr_nxt = (rd_ptr + BL_A == SIZE_A) ? '0 : rd_ptr + BL_A;

  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_rd       <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      wr_burst_req  <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      wr_burst_addr <= BASE_A;
      rd_burst_addr <= BASE_A;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state         <= WR_REQ;
            wr_burst_req  <= 1'b1;
            wr_burst_addr <= BASE_A + wr_ptr;
            last_rd       <= 1'b0;
          end else if (grant_rd) begin
            state         <= RD_REQ;
            rd_burst_req  <= 1'b1;
            rd_burst_addr <= BASE_A + rd_ptr;
            last_rd       <= 1'b1;
          end
        end
        // A finish seen while still requesting retires the burst outright.
        WR_REQ: begin
          if (wr_burst_finish) begin
            state        <= IDLE;
            wr_burst_req <= 1'b0;
            wr_ptr       <= wr_ptr_nxt;
            fill_level   <= fill_level + BL_L;
            wr_done      <= 1'b1;
          end else if (wr_burst_data_req) begin
            state        <= WR_BUSY;
            wr_burst_req <= 1'b0;
          end
        end
        WR_BUSY: begin
          if (wr_burst_finish) begin
            state      <= IDLE;
            wr_ptr     <= wr_ptr_nxt;
            fill_level <= fill_level + BL_L;
            wr_done    <= 1'b1;
          end
        end
        RD_REQ: begin
          if (rd_burst_finish) begin
            state        <= IDLE;
            rd_burst_req <= 1'b0;
            rd_ptr       <= rd_ptr_nxt;
            fill_level   <= fill_level - BL_L;
            rd_done      <= 1'b1;
          end else if (rd_burst_data_valid) begin
            state        <= RD_BUSY;
            rd_burst_req <= 1'b0;
          end
        end
        RD_BUSY: begin
          if (rd_burst_finish) begin
            state      <= IDLE;
            rd_ptr     <= rd_ptr_nxt;
            fill_level <= fill_level - BL_L;
            rd_done    <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          wr_burst_req <= 1'b0;
          rd_burst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Bench for ddr_burst_arbiter: directed scenarios followed by random traffic,
// checked against a word-count model of the circular buffer.
module tb_ddr_burst_arbiter;

  localparam int BL   = 5;
  localparam int BASE = 0;
  localparam int SIZE = 40;
  localparam int LW   = 16;

  logic          phy_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          local_init_done = 1'b0;
  logic          wr_src_ready = 1'b0;
  logic          rd_sink_ready = 1'b0;
  logic          wr_burst_data_req = 1'b0;
  logic          wr_burst_finish = 1'b0;
  logic          rd_burst_data_valid = 1'b0;
  logic          rd_burst_finish = 1'b0;
  logic          wr_burst_req;
  logic          rd_burst_req;
  logic [9:0]    wr_burst_len;
  logic [9:0]    rd_burst_len;
  logic [24:0]   wr_burst_addr;
  logic [24:0]   rd_burst_addr;
  logic          wr_done;
  logic          rd_done;
  logic [LW-1:0] fill_level;
  logic          buf_full;
  logic          buf_empty;
  logic [2:0]    state_out;

  ddr_burst_arbiter #(
    .BURST_LEN(BL), .REGION_BASE(BASE), .REGION_SIZE(SIZE), .LVL_W(LW)
  ) dut (
    .phy_clk(phy_clk), .rst_n(rst_n), .local_init_done(local_init_done),
    .wr_src_ready(wr_src_ready), .rd_sink_ready(rd_sink_ready),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish(wr_burst_finish), .rd_burst_req(rd_burst_req),
    .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .wr_done(wr_done), .rd_done(rd_done), .fill_level(fill_level),
    .buf_full(buf_full), .buf_empty(buf_empty), .state_out(state_out)
  );

  always #5 phy_clk = ~phy_clk;

  int total = 0;
  int bad = 0;

  // Model: total words moved each way; everything else derives from these.
  int m_wr_words, m_rd_words, m_wr_addr, m_rd_addr;
  bit m_last_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_words = 0;
    m_rd_words = 0;
    m_wr_addr  = BASE;
    m_rd_addr  = BASE;
    m_last_rd  = 1'b1;
  endtask

  task automatic check_levels();
    int f;
    f = m_wr_words - m_rd_words;
    chk("fill", fill_level, f);
    chk("full", buf_full, f > SIZE - BL);
    chk("empty", buf_empty, f < BL);
  endtask

  task automatic drive(input bit is_wr, input bit acc, input bit fin);
    if (is_wr) begin
      wr_burst_data_req = acc;
      wr_burst_finish   = fin;
    end else begin
      rd_burst_data_valid = acc;
      rd_burst_finish     = fin;
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns 0 none, 1 write, 2 read.
  task automatic arbitrate(input bit wr_rdy, input bit rd_rdy, input bit init, output int g);
    bit we, re;
    int f;
    f  = m_wr_words - m_rd_words;
    we = wr_rdy && (f + BL <= SIZE);
    re = rd_rdy && (f >= BL);
    g  = 0;
    if (init) begin
      if (we && re) g = m_last_rd ? 1 : 2;
      else if (we)  g = 1;
      else if (re)  g = 2;
    end
    wr_src_ready    = wr_rdy;
    rd_sink_ready   = rd_rdy;
    local_init_done = init;
    @(negedge phy_clk);
    if (g == 1) begin m_wr_addr = BASE + (m_wr_words % SIZE); m_last_rd = 1'b0; end
    if (g == 2) begin m_rd_addr = BASE + (m_rd_words % SIZE); m_last_rd = 1'b1; end
    chk("wr_req", wr_burst_req, g == 1);
    chk("rd_req", rd_burst_req, g == 2);
    chk("grant_state", state_out, (g == 1) ? 1 : (g == 2) ? 3 : 0);
    chk("done_low", {wr_done, rd_done}, 0);
    chk("wr_addr", wr_burst_addr, m_wr_addr);
    chk("rd_addr", rd_burst_addr, m_rd_addr);
    check_levels();
  endtask

  // mode 0: accept then finish later; 1: accept and finish together; 2: finish before accept
  task automatic run_burst(input bit is_wr, input int mode, input int acc_dly, input int fin_dly);
    logic [2:0] s_req, s_busy;
    s_req  = is_wr ? 3'd1 : 3'd3;
    s_busy = is_wr ? 3'd2 : 3'd4;
    for (int i = 0; i < acc_dly; i++) begin
      @(negedge phy_clk);
      chk("req_hold", is_wr ? wr_burst_req : rd_burst_req, 1);
      chk("req_state", state_out, s_req);
    end
    if (mode == 0) begin
      drive(is_wr, 1'b1, 1'b0);
      @(negedge phy_clk);
      drive(is_wr, 1'b0, 1'b0);
      chk("busy_state", state_out, s_busy);
      chk("req_drop", {wr_burst_req, rd_burst_req}, 0);
      for (int i = 0; i < fin_dly; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          if (is_wr) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) local_init_done = 1'b0;
        @(negedge phy_clk);
        if (is_wr) rd_burst_finish = 1'b0; else wr_burst_finish = 1'b0;
        chk("busy_hold", state_out, s_busy);
        chk("stray_done", {wr_done, rd_done}, 0);
      end
      drive(is_wr, 1'b0, 1'b1);
    end else begin
      drive(is_wr, mode == 1, 1'b1);
    end
    @(negedge phy_clk);
    drive(is_wr, 1'b0, 1'b0);
    if (is_wr) m_wr_words += BL; else m_rd_words += BL;
    chk("wr_done", wr_done, is_wr);
    chk("rd_done", rd_done, !is_wr);
    chk("retire_state", state_out, 0);
    chk("retire_req", {wr_burst_req, rd_burst_req}, 0);
    check_levels();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    local_init_done = 1'b0;
    wr_src_ready = 1'b0;
    rd_sink_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge phy_clk);
    model_reset();
    chk("rst_state", state_out, 0);
    chk("rst_reqs", {wr_burst_req, rd_burst_req, wr_done, rd_done}, 0);
    chk("rst_addrs", {wr_burst_addr, rd_burst_addr}, {25'(BASE), 25'(BASE)});
    chk("rst_lens", {wr_burst_len, rd_burst_len}, {10'(BL), 10'(BL)});
    check_levels();
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    model_reset();
    apply_reset();

    // Init gate: no grants while calibration is pending.
    for (int i = 0; i < 100; i++) arbitrate(1'b1, 1'b0, 1'b0, g);
    arbitrate(1'b1, 1'b0, 1'b1, g);
    run_burst(1'b1, 0, 2, 5);
    arbitrate(1'b1, 1'b0, 1'b1, g);

    // Reset while in WR_BUSY: outputs return to reset values immediately.
    drive(1'b1, 1'b1, 1'b0);
    @(negedge phy_clk);
    drive(1'b1, 1'b0, 1'b0);
    chk("pre_rst_busy", state_out, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", state_out, 0);
    chk("async_outs", {wr_burst_req, rd_burst_req, wr_done, rd_done}, 0);
    chk("async_fill", fill_level, 0);
    chk("async_addr", {wr_burst_addr, rd_burst_addr}, {25'(BASE), 25'(BASE)});
    @(negedge phy_clk);
    rst_n = 1'b1;
    model_reset();
    wr_src_ready = 1'b0;
    @(negedge phy_clk);
    chk("post_rst_empty", buf_empty, 1);
    chk("post_rst_state", state_out, 0);

    // Round robin from fill=10.
    for (int i = 0; i < 2; i++) begin
      arbitrate(1'b1, 1'b0, 1'b1, g);
      run_burst(1'b1, 0, 0, 1);
    end
    for (int i = 0; i < 6; i++) begin
      arbitrate(1'b1, 1'b1, 1'b1, g);
      if (g != 0) run_burst(g == 1, 0, 1, 1);
    end

    // Full and pointer wrap.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      arbitrate(1'b1, 1'b0, 1'b1, g);
      if (g != 0) run_burst(1'b1, i % 3, 0, 2);
    end
    chk("full_flag", buf_full, 1);
    for (int i = 0; i < 3; i++) arbitrate(1'b1, 1'b0, 1'b1, g);
    arbitrate(1'b0, 1'b1, 1'b1, g);
    if (g != 0) run_burst(1'b0, 0, 1, 1);
    arbitrate(1'b1, 1'b0, 1'b1, g);
    chk("wrap_addr", wr_burst_addr, BASE);
    if (g != 0) run_burst(1'b1, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      arbitrate(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) != 0, g);
      if (g != 0)
        run_burst(g == 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                  $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
